cmd_read_vertex: RTL and testbench

//   Vertex readback engine: on a request naming START and COUNT, reads COUNT 64-bit

---
 rtl/cmd_read_vertex.sv | 227 ++++++++++++++++++++++
 tb/tb_cmd_read_vertex.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_read_vertex.sv
// -----------------------------------------------------------------------------
// cmd_read_vertex
//   Vertex readback engine. A request names a first vertex (req_start) and a
//   number of vertices (req_count). The engine reads that many 64-bit words
//   from vertex RAM and streams one response packet, a byte at a time, over a
//   valid/ready byte channel towards the host UART TX path.
//
//   Packet: SYNC(AA) LEN OPCODE COUNT START[15:8] START[7:0]
//           { 8 bytes per vertex } CRC
//   LEN = 5 + 8*COUNT. The CRC-8 (poly 0x07, init 0) covers LEN through the
//   last payload byte.
//
// Ports
//   CLK           clock, rising edge
//   rst           synchronous reset, active-high
//   req_pulse     one-cycle request strobe (sampled only while idle)
//   req_start     first vertex index
//   req_count     number of vertices (1..MAX_COUNT)
//   vertex_raddr  RAM read address (holds between reads)
//   vertex_re     RAM read enable; data returns one cycle later
//   vertex_rdata  RAM read data
//   tx_data       response byte
//   tx_valid      tx_data valid; held with stable data until tx_ready
//   tx_ready      sink accepts the byte when tx_valid && tx_ready
//   BUSY          high from accepted request until the CRC byte is taken
//   done_pulse    one cycle after the CRC byte is accepted
//   err_pulse     one cycle after a rejected request
// -----------------------------------------------------------------------------
module cmd_read_vertex #(
  parameter int          DEPTH     = 1024,
  parameter int          DW        = 64,
  parameter int          MAX_COUNT = 31,
  parameter logic [7:0]  OPCODE    = 8'h04,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          req_pulse,
  input  logic [15:0]   req_start,
  input  logic [7:0]    req_count,
  output logic [AW-1:0] vertex_raddr,
  output logic          vertex_re,
  input  logic [DW-1:0] vertex_rdata,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          BUSY,
  output logic          done_pulse,
  output logic          err_pulse
);

  localparam logic [7:0]  MAX_COUNT_8 = 8'(MAX_COUNT);
  localparam logic [16:0] DEPTH_17    = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_LATCH,
    S_PAYLOAD,
    S_CRC
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [15:0]   start_q;
  logic [7:0]    count_q;
  logic [2:0]    hdr_idx;
  logic [2:0]    byte_idx;
  logic [4:0]    vtx_idx;
  logic [63:0]   vtx_reg;
  logic [7:0]    crc;

  logic          req_ok;
  logic          accept;
  logic          more_vertices;
  logic [7:0]    hdr_byte;
  logic [7:0]    pay_byte;

  // CRC-8, poly 0x07, MSB first, one whole byte per call.
  function automatic logic [7:0] crc8_update(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // The range check uses a 17-bit sum so start+count can never wrap silently.
  assign req_ok = (req_count != 8'd0) &&
                  (req_count <= MAX_COUNT_8) &&
                  (({1'b0, req_start} + {9'd0, req_count}) <= DEPTH_17);

  assign tx_valid      = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_CRC);
  assign accept        = tx_valid && tx_ready;
  assign BUSY          = (state != S_IDLE);
  assign vertex_re     = (state == S_FETCH);
  assign more_vertices = ({3'd0, vtx_idx} + 8'd1) < count_q;

  // Header byte select. COUNT is at most 31, so LEN fits in 8 bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0:    hdr_byte = 8'hAA;
      3'd1:    hdr_byte = 8'd5 + {count_q[4:0], 3'b000};
      3'd2:    hdr_byte = OPCODE;
      3'd3:    hdr_byte = count_q;
      3'd4:    hdr_byte = start_q[15:8];
      default: hdr_byte = start_q[7:0];
    endcase
  end

  // Payload byte order swaps the bytes within each 16-bit half, except the top
  // half which goes out low byte first.
  always_comb begin
    pay_byte = 8'h00;
    case (byte_idx)
      3'd0:    pay_byte = vtx_reg[15:8];
      3'd1:    pay_byte = vtx_reg[7:0];
      3'd2:    pay_byte = vtx_reg[31:24];
      3'd3:    pay_byte = vtx_reg[23:16];
      3'd4:    pay_byte = vtx_reg[47:40];
      3'd5:    pay_byte = vtx_reg[39:32];
      3'd6:    pay_byte = vtx_reg[55:48];
      default: pay_byte = vtx_reg[63:56];
    endcase
  end

  // Next-state and byte-mux. tx_data is forced to 0 whenever tx_valid is low.
  always_comb begin
    state_next = state;
    tx_data    = 8'h00;
    case (state)
      S_IDLE: begin
        if (req_pulse && req_ok) state_next = S_HDR;
      end
      S_HDR: begin
        tx_data = hdr_byte;
        if (accept && (hdr_idx == 3'd5)) state_next = S_FETCH;
      end
      S_FETCH: state_next = S_LATCH;
      S_LATCH: state_next = S_PAYLOAD;
      S_PAYLOAD: begin
        tx_data = pay_byte;
        if (accept && (byte_idx == 3'd7)) state_next = more_vertices ? S_FETCH : S_CRC;
      end
      S_CRC: begin
        tx_data = crc;
        if (accept) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      start_q      <= '0;
      count_q      <= '0;
      hdr_idx      <= '0;
      byte_idx     <= '0;
      vtx_idx      <= '0;
      vtx_reg      <= '0;
      crc          <= '0;
      vertex_raddr <= '0;
      done_pulse   <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_pulse) begin
            if (req_ok) begin
              start_q <= req_start;
              count_q <= req_count;
              hdr_idx <= '0;
              vtx_idx <= '0;
              crc     <= '0;
            end else begin
              err_pulse <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (accept) begin
            hdr_idx <= hdr_idx + 3'd1;
            // SYNC is outside the CRC.
            if (hdr_idx != 3'd0) crc <= crc8_update(crc, tx_data);
            if (hdr_idx == 3'd5) vertex_raddr <= start_q[AW-1:0];
          end
        end
        S_LATCH: begin
          vtx_reg  <= vertex_rdata[63:0];
          byte_idx <= '0;
        end
        S_PAYLOAD: begin
          if (accept) begin
            crc      <= crc8_update(crc, tx_data);
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx == 3'd7) begin
              vtx_idx <= vtx_idx + 5'd1;
              // Address only moves ahead of a real read so it holds otherwise.
              if (more_vertices)
                vertex_raddr <= start_q[AW-1:0] + AW'(vtx_idx) + AW'(1);
            end
          end
        end
        S_CRC: begin
          if (accept) done_pulse <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_read_vertex.sv
// -----------------------------------------------------------------------------
// tb_cmd_read_vertex
//   Self-checking bench for cmd_read_vertex. Expected response bytes are pushed
//   onto a scoreboard queue when a request is issued and popped as the DUT
//   hands bytes over. A behavioural synchronous RAM serves vertex reads.
// -----------------------------------------------------------------------------
module tb_cmd_read_vertex;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          CLK = 1'b0;
  logic          rst;
  logic          req_pulse;
  logic [15:0]   req_start;
  logic [7:0]    req_count;
  logic [AW-1:0] vertex_raddr;
  logic          vertex_re;
  logic [63:0]   vertex_rdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          BUSY;
  logic          done_pulse;
  logic          err_pulse;

  cmd_read_vertex #(
    .DEPTH(DEPTH), .DW(64), .MAX_COUNT(31), .OPCODE(8'h04)
  ) dut (
    .CLK(CLK), .rst(rst),
    .req_pulse(req_pulse), .req_start(req_start), .req_count(req_count),
    .vertex_raddr(vertex_raddr), .vertex_re(vertex_re), .vertex_rdata(vertex_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .BUSY(BUSY), .done_pulse(done_pulse), .err_pulse(err_pulse)
  );

  always #5 CLK = ~CLK;

  // Behavioural vertex RAM: data one cycle after the read enable.
  logic [63:0] mem [DEPTH];
  always @(posedge CLK) if (vertex_re) vertex_rdata <= mem[vertex_raddr];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Golden CRC-8 (poly 0x07), bit-serial LFSR form.
  function automatic logic [7:0] crc8_golden(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  logic [7:0]    sb[$];
  logic [AW-1:0] addr_q[$];
  int            cyc       = 0;
  int            req_cyc   = 0;
  int            acc_cnt   = 0;
  int            valid_cnt = 0;
  int            done_cnt  = 0;
  int            err_cnt   = 0;
  logic          stall_prev = 1'b0;
  logic [7:0]    stall_data = 8'h00;
  logic          rand_ready  = 1'b0;
  logic          ready_level = 1'b1;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Sole driver of tx_ready, updated just after each rising edge.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : ready_level;
    end
  end

  // Output monitor on the falling edge: a byte seen valid&&ready here is taken
  // at the next rising edge.
  initial forever begin
    @(negedge CLK);
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", 32'(tx_valid), 32'd1);
        check("stall_data_held", 32'(tx_data), 32'(stall_data));
      end
      if (tx_valid) begin
        valid_cnt++;
        if (tx_ready) begin
          if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
          else check("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
          acc_cnt++;
        end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (done_pulse) done_cnt++;
      if (err_pulse)  err_cnt++;
      if (vertex_re)  addr_q.push_back(vertex_raddr);
    end
  end

  task automatic push_with_crc(input logic [7:0] pkt[$]);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 1; i < pkt.size(); i++) c = crc8_golden(c, pkt[i]);
    foreach (pkt[i]) sb.push_back(pkt[i]);
    sb.push_back(c);
  endtask

  // Packet model built from the RAM contents.
  task automatic push_packet(input int start, input int count);
    logic [7:0]  pkt[$];
    logic [63:0] w;
    pkt = {};
    pkt.push_back(8'hAA);
    pkt.push_back(8'(5 + 8 * count));
    pkt.push_back(8'h04);
    pkt.push_back(8'(count));
    pkt.push_back(8'(start >> 8));
    pkt.push_back(8'(start));
    for (int v = 0; v < count; v++) begin
      w = mem[start + v];
      pkt.push_back(w[15:8]);  pkt.push_back(w[7:0]);
      pkt.push_back(w[31:24]); pkt.push_back(w[23:16]);
      pkt.push_back(w[47:40]); pkt.push_back(w[39:32]);
      pkt.push_back(w[55:48]); pkt.push_back(w[63:56]);
    end
    push_with_crc(pkt);
  endtask

  // Literal byte list for the two known vertices at 0x10/0x11.
  task automatic push_literal();
    logic [7:0] pkt[$];
    pkt = '{8'hAA, 8'h15, 8'h04, 8'h02, 8'h00, 8'h10,
            8'h00, 8'h64, 8'h00, 8'hC8, 8'h00, 8'h00, 8'hE3, 8'h10,
            8'h00, 8'h32, 8'h00, 8'h96, 8'h00, 8'h00, 8'h4F, 8'h20};
    push_with_crc(pkt);
  endtask

  // Returns #1 after the edge that samples req_pulse.
  task automatic send_req(input logic [15:0] s, input logic [7:0] c);
    @(posedge CLK);
    #1;
    req_pulse = 1'b1;
    req_start = s;
    req_count = c;
    @(posedge CLK);
    #1;
    req_pulse = 1'b0;
    req_cyc   = cyc;
  endtask

  task automatic wait_done(input int max_cycles);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cycles && done_cnt == d0; i++) begin
      @(negedge CLK);
      #1;
    end
    check("done_seen_once", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int e0, v0, base;
    logic [15:0] rej_start [3];
    logic [7:0]  rej_count [3];

    rst = 1'b1; req_pulse = 1'b0; req_start = '0; req_count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom(), $urandom()};
    mem[16] = 64'h10E3_0000_00C8_0064;
    mem[17] = 64'h204F_0000_0096_0032;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(done_pulse), 32'd0);
    check("rst_err", 32'(err_pulse), 32'd0);
    check("rst_re", 32'(vertex_re), 32'd0);
    check("rst_raddr", 32'(vertex_raddr), 32'd0);
    rst = 1'b0;

    // Known vertices, back-to-back acceptance, exact timing
    addr_q.delete();
    push_literal();
    send_req(16'h0010, 8'd2);
    check("first_sync_valid", 32'(tx_valid), 32'd1);
    check("first_sync_data", 32'(tx_data), 32'hAA);
    check("busy_after_req", 32'(BUSY), 32'd1);
    wait_done(100);
    check("pkt_cycles", 32'(cyc - req_cyc), 32'd27);
    check("busy_after_done", 32'(BUSY), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_reads", 32'(addr_q.size()), 32'd2);
    if (addr_q.size() == 2) begin
      check("t1_addr0", 32'(addr_q[0]), 32'd16);
      check("t1_addr1", 32'(addr_q[1]), 32'd17);
    end

    // Same request under random backpressure
    rand_ready = 1'b1;
    push_literal();
    send_req(16'h0010, 8'd2);
    wait_done(2000);
    rand_ready = 1'b0;
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Rejected requests
    rej_start = '{16'd0, 16'd0, 16'd1020};
    rej_count = '{8'd0, 8'd32, 8'd5};
    e0 = err_cnt;
    v0 = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      send_req(rej_start[i], rej_count[i]);
      check("rej_err_pulse", 32'(err_pulse), 32'd1);
      check("rej_busy", 32'(BUSY), 32'd0);
      repeat (3) @(negedge CLK);
    end
    check("rej_err_count", 32'(err_cnt - e0), 32'd3);
    check("rej_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Top-of-RAM single vertex
    addr_q.delete();
    push_packet(1023, 1);
    send_req(16'd1023, 8'd1);
    wait_done(100);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    check("t4_reads", 32'(addr_q.size()), 32'd1);
    if (addr_q.size() == 1) check("t4_addr", 32'(addr_q[0]), 32'd1023);

    // Maximum count
    push_packet(0, 31);
    send_req(16'd0, 8'd31);
    wait_done(400);
    check("t4_max_sb_empty", 32'(sb.size()), 32'd0);

    // Request while busy is ignored
    addr_q.delete();
    push_literal();
    e0 = err_cnt;
    send_req(16'h0010, 8'd2);
    repeat (8) @(posedge CLK);
    send_req(16'h0000, 8'd3);
    wait_done(100);
    check("t5_no_err", 32'(err_cnt - e0), 32'd0);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    check("t5_reads", 32'(addr_q.size()), 32'd2);
    if (addr_q.size() == 2) check("t5_addr1", 32'(addr_q[1]), 32'd17);
    v0 = valid_cnt;
    repeat (4) @(negedge CLK);
    check("t5_idle_after", 32'(valid_cnt - v0), 32'd0);

    // Reset while presenting payload byte 3 of vertex 1
    push_literal();
    base = acc_cnt;
    e0 = done_cnt;
    send_req(16'h0010, 8'd2);
    for (int i = 0; i < 200 && acc_cnt != base + 18; i++) begin
      @(negedge CLK);
      #1;
    end
    check("t6_abort_point", 32'(acc_cnt - base), 32'd18);
    rst = 1'b1;
    @(posedge CLK);
    #1;
    check("t6_valid_after_rst", 32'(tx_valid), 32'd0);
    check("t6_busy_after_rst", 32'(BUSY), 32'd0);
    check("t6_no_done", 32'(done_cnt - e0), 32'd0);
    sb.delete();
    rst = 1'b0;
    push_literal();
    send_req(16'h0010, 8'd2);
    wait_done(100);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
